// File: rtl/hash_round_sequencer.sv
// hash_round_sequencer
//
// Sequences one double-SHA-256 nonce attempt in front of the round counter:
// load pass 0, run ROUNDS round strobes, load pass 1, run ROUNDS round
// strobes, pulse done and advance the nonce. A watchdog returns the block to
// IDLE with a sticky error if the counter never reports rollover.
//
// Ports
//   clk, n_rst         clock, asynchronous active-low reset
//   start              request one attempt (IDLE only)
//   abort              cancel the attempt in progress
//   nonce_load         load nonce_init into the nonce register (IDLE only)
//   nonce_init[31:0]   starting nonce
//   cnt_rollover_flag  rollover flag from the round counter
//   cnt_count_enable   counter increment enable / datapath round strobe
//   cnt_clear          synchronous counter clear
//   cnt_rollover_val   rollover value, constant ROUNDS
//   load_msg           one-cycle message-load pulse for the current pass
//   pass               0 for the first SHA pass, 1 for the second
//   busy               high whenever the sequencer is not in IDLE
//   done               one-cycle pulse at attempt completion
//   nonce[31:0]        current nonce
//   nonce_wrap         one-cycle pulse when the nonce wraps to 0
//   error              sticky watchdog error, cleared by an accepted start
module hash_round_sequencer #(
  parameter int NUM_CNT_BITS = 7,
  parameter int ROUNDS       = 64
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    nonce_load,
  input  logic [31:0]             nonce_init,
  input  logic                    cnt_rollover_flag,
  output logic                    cnt_count_enable,
  output logic                    cnt_clear,
  output logic [NUM_CNT_BITS-1:0] cnt_rollover_val,
  output logic                    load_msg,
  output logic                    pass,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             nonce,
  output logic                    nonce_wrap,
  output logic                    error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD0 = 3'd1,
    RUN0  = 3'd2,
    LOAD1 = 3'd3,
    RUN1  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // One extra bit so ROUNDS+1 fits even at the top of the legal ROUNDS range.
  localparam int                    WD_W     = NUM_CNT_BITS + 1;
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(ROUNDS + 1);
  localparam logic [NUM_CNT_BITS-1:0] ROLL_VAL = NUM_CNT_BITS'(ROUNDS);

  state_t          state;
  state_t          state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            in_run;
  logic            wd_trip;
  logic            start_ok;

  assign in_run = (state == RUN0) || (state == RUN1);

  // A normal pass sees the flag on its (ROUNDS+1)th RUN cycle; the watchdog
  // fires on the (ROUNDS+2)th RUN cycle if the flag still has not arrived.
  assign wd_trip  = in_run && !cnt_rollover_flag && (wd_cnt == WD_LAST);
  assign start_ok = (state == IDLE) && start && !abort;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = LOAD0;
      LOAD0:   state_nxt = RUN0;
      RUN0:    if (cnt_rollover_flag) state_nxt = LOAD1;
      LOAD1:   state_nxt = RUN1;
      RUN1:    if (cnt_rollover_flag) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Later assignments win: abort outranks the watchdog, which outranks
    // the normal transitions above.
    if (wd_trip)
      state_nxt = IDLE;
    if (abort && (state != IDLE))
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      wd_cnt <= '0;
      error  <= 1'b0;
      nonce  <= '0;
    end else begin
      state <= state_nxt;

      // Cleared outside RUN, so every LOAD restarts the watchdog.
      if (in_run)
        wd_cnt <= wd_cnt + 1'b1;
      else
        wd_cnt <= '0;

      if (start_ok)
        error <= 1'b0;
      else if (wd_trip && !abort)
        error <= 1'b1;

      // Increment happens on the edge leaving DONE, so done and nonce_wrap
      // are reported alongside the pre-increment value.
      if ((state == IDLE) && nonce_load)
        nonce <= nonce_init;
      else if ((state == DONE) && !abort)
        nonce <= nonce + 32'd1;
    end
  end

  assign cnt_count_enable = in_run && !cnt_rollover_flag;
  assign cnt_clear        = (state == IDLE) || (state == LOAD0) || (state == LOAD1);
  assign cnt_rollover_val = ROLL_VAL;
  assign load_msg         = (state == LOAD0) || (state == LOAD1);
  assign pass             = (state == LOAD1) || (state == RUN1) || (state == DONE);
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign nonce_wrap       = (state == DONE) && (nonce == 32'hFFFF_FFFF);

endmodule

// File: tb/tb_hash_round_sequencer.sv
module tb_hash_round_sequencer;

  localparam int NUM_CNT_BITS = 7;
  localparam int ROUNDS       = 64;
  localparam int ATTEMPT      = 2 * ROUNDS + 5;

  logic                    clk = 1'b0;
  logic                    n_rst = 1'b0;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic                    nonce_load = 1'b0;
  logic [31:0]             nonce_init = 32'd0;
  logic                    cnt_rollover_flag;
  logic                    cnt_count_enable;
  logic                    cnt_clear;
  logic [NUM_CNT_BITS-1:0] cnt_rollover_val;
  logic                    load_msg;
  logic                    pass;
  logic                    busy;
  logic                    done;
  logic [31:0]             nonce;
  logic                    nonce_wrap;
  logic                    error;

  hash_round_sequencer #(
    .NUM_CNT_BITS(NUM_CNT_BITS),
    .ROUNDS      (ROUNDS)
  ) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .start            (start),
    .abort            (abort),
    .nonce_load       (nonce_load),
    .nonce_init       (nonce_init),
    .cnt_rollover_flag(cnt_rollover_flag),
    .cnt_count_enable (cnt_count_enable),
    .cnt_clear        (cnt_clear),
    .cnt_rollover_val (cnt_rollover_val),
    .load_msg         (load_msg),
    .pass             (pass),
    .busy             (busy),
    .done             (done),
    .nonce            (nonce),
    .nonce_wrap       (nonce_wrap),
    .error            (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Round counter model; stuck forces the flag seen by the sequencer low.
  int   m_cnt;
  logic m_flag;
  logic stuck = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_cnt  <= 0;
      m_flag <= 1'b0;
    end else if (cnt_clear) begin
      m_cnt  <= 0;
      m_flag <= 1'b0;
    end else if (cnt_count_enable) begin
      m_cnt  <= m_cnt + 1;
      m_flag <= ((m_cnt + 1) == ROUNDS);
    end
  end

  assign cnt_rollover_flag = m_flag & ~stuck;

  typedef struct {
    int          cyc;
    logic [31:0] nonce;
    logic        wrap;
  } exp_t;

  exp_t        exp_q[$];
  int          load_cyc_q[$];
  logic        load_pass_q[$];
  int          en_cnt = 0;
  logic [31:0] exp_nonce = 32'd0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (cnt_count_enable) en_cnt++;
        if (load_msg) begin
          load_cyc_q.push_back(cyc);
          load_pass_q.push_back(pass);
        end
        if (done) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
          end else begin
            e = exp_q.pop_front();
            vectors++;
            if (cyc !== e.cyc) begin
              miscompares++;
              $display("FAIL done_cycle: got %0d required %0d", cyc, e.cyc);
            end
            vectors++;
            if (nonce !== e.nonce) begin
              miscompares++;
              $display("FAIL done_nonce: got %h required %h", nonce, e.nonce);
            end
            vectors++;
            if (nonce_wrap !== e.wrap) begin
              miscompares++;
              $display("FAIL done_wrap: got %b required %b", nonce_wrap, e.wrap);
            end
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    t0    = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic expect_attempt(input int t0);
    exp_t e;
    e.cyc   = t0 + ATTEMPT;
    e.nonce = exp_nonce;
    e.wrap  = (exp_nonce == 32'hFFFF_FFFF);
    exp_q.push_back(e);
    exp_nonce = exp_nonce + 32'd1;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 4 * ATTEMPT) begin
      step();
      i++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_done_timeout: pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #12;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_clear", cnt_clear, 1'b1);
    check_bit("rst_enable", cnt_count_enable, 1'b0);
    check_bit("rst_load_msg", load_msg, 1'b0);
    check_bit("rst_pass", pass, 1'b0);
    check_bit("rst_error", error, 1'b0);
    check_bit("rst_wrap", nonce_wrap, 1'b0);
    check_word("rst_nonce", nonce, 32'd0);
    check_word("rst_rollover_val", 32'(cnt_rollover_val), 32'(ROUNDS));
    @(negedge clk);
    n_rst = 1'b1;
    step();
    step();
  endtask

  task automatic test_basic();
    int t0;
    nonce_init = 32'h10;
    nonce_load = 1'b1;
    step();
    nonce_load = 1'b0;
    exp_nonce  = 32'h10;
    check_word("basic_loaded", nonce, 32'h10);
    en_cnt = 0;
    load_cyc_q.delete();
    load_pass_q.delete();
    pulse_start(t0);
    expect_attempt(t0);
    wait_done("basic");
    check_word("basic_enables", 32'(en_cnt), 32'(2 * ROUNDS));
    check_word("basic_loads", 32'(load_cyc_q.size()), 32'd2);
    if (load_cyc_q.size() == 2) begin
      check_word("basic_load0_cyc", 32'(load_cyc_q[0]), 32'(t0 + 1));
      check_word("basic_load1_cyc", 32'(load_cyc_q[1]), 32'(t0 + ROUNDS + 3));
      check_bit("basic_load0_pass", load_pass_q[0], 1'b0);
      check_bit("basic_load1_pass", load_pass_q[1], 1'b1);
    end
    check_word("basic_nonce", nonce, 32'h11);
    check_bit("basic_idle", busy, 1'b0);
  endtask

  task automatic test_wrap();
    int t0;
    nonce_init = 32'hFFFF_FFFF;
    nonce_load = 1'b1;
    start      = 1'b1;
    t0         = cyc;
    step();
    start      = 1'b0;
    nonce_load = 1'b0;
    exp_nonce  = 32'hFFFF_FFFF;
    expect_attempt(t0);
    wait_done("wrap");
    check_word("wrap_nonce", nonce, 32'd0);
  endtask

  task automatic test_abort();
    int t0;
    int t1;
    pulse_start(t0);
    go_to(t0 + 41);
    check_bit("abort_busy_before", busy, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_clear", cnt_clear, 1'b1);
    check_bit("abort_done", done, 1'b0);
    check_word("abort_nonce", nonce, exp_nonce);
    step();
    pulse_start(t1);
    expect_attempt(t1);
    wait_done("abort_restart");
    check_word("abort_restart_nonce", nonce, exp_nonce);
  endtask

  task automatic test_watchdog();
    int t0;
    int t1;
    stuck = 1'b1;
    pulse_start(t0);
    go_to(t0 + 67);
    check_bit("wd_error_before", error, 1'b0);
    check_bit("wd_busy_before", busy, 1'b1);
    step();
    check_bit("wd_error", error, 1'b1);
    check_bit("wd_idle", busy, 1'b0);
    check_bit("wd_clear", cnt_clear, 1'b1);
    check_word("wd_nonce", nonce, exp_nonce);
    stuck = 1'b0;
    step();
    check_bit("wd_error_sticky", error, 1'b1);
    pulse_start(t1);
    check_bit("wd_error_cleared", error, 1'b0);
    expect_attempt(t1);
    wait_done("wd_restart");
  endtask

  task automatic test_ignored();
    int t0;
    pulse_start(t0);
    expect_attempt(t0);
    go_to(t0 + ROUNDS + 3);
    check_bit("ign_load1_msg", load_msg, 1'b1);
    check_bit("ign_load1_pass", pass, 1'b1);
    nonce_init = 32'hDEAD_BEEF;
    nonce_load = 1'b1;
    step();
    nonce_load = 1'b0;
    go_to(t0 + ROUNDS + 10);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ignored");
    repeat (10) step();
    check_word("ign_nonce", nonce, exp_nonce);
    check_bit("ign_idle", busy, 1'b0);
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_bit("sa_busy", busy, 1'b0);
    check_bit("sa_clear", cnt_clear, 1'b1);
    step();
    check_bit("sa_busy_later", busy, 1'b0);
    pulse_start(t0);
    expect_attempt(t0);
    go_to(t0 + ATTEMPT + 1);
    check_bit("b2b_idle_after_done", busy, 1'b0);
    pulse_start(t1);
    check_bit("b2b_accepted", load_msg, 1'b1);
    expect_attempt(t1);
    wait_done("b2b");
    check_word("b2b_nonce", nonce, exp_nonce);
  endtask

  task automatic test_async_reset();
    int t0;
    pulse_start(t0);
    go_to(t0 + 30);
    #2;
    n_rst = 1'b0;
    #1;
    check_bit("arst_busy", busy, 1'b0);
    check_bit("arst_clear", cnt_clear, 1'b1);
    check_bit("arst_enable", cnt_count_enable, 1'b0);
    check_word("arst_nonce", nonce, 32'd0);
    @(negedge clk);
    n_rst     = 1'b1;
    exp_nonce = 32'd0;
    step();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_wrap();
    test_abort();
    test_watchdog();
    test_ignored();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
